// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_port_arbiter
// Purpose  : Schedules one write stream and two read streams onto a 2-read /
//            1-write register file. No two granted ports ever share an
//            address in the same cycle. Read data returns through one
//            2-entry response FIFO per read channel, with backpressure.
// Ports    : clk/resetn             - clock, synchronous active-low reset
//            w_*                    - write request (valid/ready)
//            rK_valid/addr/ready    - read request, K = 1, 2
//            rK_rvalid/rdata/rready - read response, K = 1, 2
//            rf_*                   - 1:1 connection to the register file
//            err_collision          - sticky flag, set if rf_collision is seen
// Options  : REGFILE_ARB_STARVE_GUARD_EN - when defined, a write that has been
//            denied STARVE_LIMIT cycles in a row is promoted above both reads.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  w_valid,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_ready,
  input  logic                  r1_valid,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic                  r1_ready,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  input  logic                  r1_rready,
  input  logic                  r2_valid,
  input  logic [ADDR_WIDTH-1:0] r2_addr,
  output logic                  r2_ready,
  output logic                  r2_rvalid,
  output logic [DATA_WIDTH-1:0] r2_rdata,
  input  logic                  r2_rready,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic [ADDR_WIDTH-1:0] rf_wad1,
  output logic                  rf_wen1,
  output logic [ADDR_WIDTH-1:0] rf_rad1,
  output logic [ADDR_WIDTH-1:0] rf_rad2,
  output logic                  rf_ren1,
  output logic                  rf_ren2,
  input  logic [DATA_WIDTH-1:0] rf_dout1,
  input  logic [DATA_WIDTH-1:0] rf_dout2,
  input  logic                  rf_collision,
  output logic                  err_collision
);

  // Per-channel views so both read channels share one generate body.
  logic [DATA_WIDTH-1:0] rf_dout_w [2];
  logic [DATA_WIDTH-1:0] head_w    [2];
  logic [1:0]            rready_w;
  logic [1:0]            elig_w;
  logic [1:0]            nempty_w;
  logic [1:0]            pend_q;
  logic                  gw, g1, g2;
  logic                  w_first;
  logic                  err_q;

  assign rf_dout_w[0] = rf_dout1;
  assign rf_dout_w[1] = rf_dout2;
  assign rready_w     = {r2_rready, r1_rready};

  // --------------------------------------------------------------------------
  // Response FIFOs. pend_q marks a read issued last cycle whose data is on
  // rf_doutK now and is pushed at the end of this cycle.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < 2; k++) begin : g_rd_chan
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            cnt_q;
    logic                  push_w;
    logic                  pop_w;

    assign push_w      = pend_q[k];
    assign pop_w       = (cnt_q != 2'd0) & rready_w[k];
    assign nempty_w[k] = (cnt_q != 2'd0);
    assign head_w[k]   = mem_q[rd_ptr_q];
    // Accept only if the in-flight read plus the stored entries, less the
    // entry leaving this cycle, leave room for one more.
    assign elig_w[k]   = (3'(pend_q[k]) + 3'(cnt_q)) < (3'd2 + 3'(pop_w));

    always_ff @(posedge clk) begin
      if (!resetn) begin
        mem_q[0] <= '0;
        mem_q[1] <= '0;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        cnt_q    <= 2'd0;
      end else begin
        if (push_w) begin
          mem_q[wr_ptr_q] <= rf_dout_w[k];
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop_w) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        cnt_q <= cnt_q + 2'(push_w) - 2'(pop_w);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Starvation guard
  // --------------------------------------------------------------------------
`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!w_valid || gw) begin
      starve_d = 4'd0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign w_first = (starve_q == STARVE_MAX);
`else
  // Fixed R1 > R2 > W; the limit only has meaning with the guard built in.
  assign w_first = 1'b0 & (STARVE_LIMIT > 0);
`endif

  // --------------------------------------------------------------------------
  // Grant: walk channels in priority order; a channel loses if its address
  // matches any channel already granted ahead of it.
  // --------------------------------------------------------------------------
  always_comb begin
    gw = 1'b0;
    g1 = 1'b0;
    g2 = 1'b0;
    if (resetn) begin
      if (w_first) begin
        gw = w_valid;
        g1 = r1_valid & elig_w[0] & ~(gw & (w_addr == r1_addr));
        g2 = r2_valid & elig_w[1] & ~(gw & (w_addr == r2_addr))
                                  & ~(g1 & (r1_addr == r2_addr));
      end else begin
        g1 = r1_valid & elig_w[0];
        g2 = r2_valid & elig_w[1] & ~(g1 & (r1_addr == r2_addr));
        gw = w_valid & ~(g1 & (w_addr == r1_addr))
                     & ~(g2 & (w_addr == r2_addr));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_q <= 2'b00;
      err_q  <= 1'b0;
    end else begin
      pend_q <= {g2, g1};
      if (rf_collision) begin
        err_q <= 1'b1;
      end
    end
  end

  assign w_ready       = gw;
  assign r1_ready      = g1;
  assign r2_ready      = g2;
  assign rf_wen1       = gw;
  assign rf_ren1       = g1;
  assign rf_ren2       = g2;
  assign rf_din        = w_data;
  assign rf_wad1       = w_addr;
  assign rf_rad1       = r1_addr;
  assign rf_rad2       = r2_addr;
  assign r1_rvalid     = nempty_w[0];
  assign r2_rvalid     = nempty_w[1];
  assign r1_rdata      = head_w[0];
  assign r2_rdata      = head_w[1];
  assign err_collision = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_port_arbiter
// Purpose  : Directed bench for regfile_port_arbiter with a behavioural
//            register file and a per-channel response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SL = 4;

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          w_valid, r1_valid, r2_valid;
  logic [AW-1:0] w_addr, r1_addr, r2_addr;
  logic [DW-1:0] w_data;
  logic          w_ready, r1_ready, r2_ready;
  logic          r1_rvalid, r2_rvalid, r1_rready, r2_rready;
  logic [DW-1:0] r1_rdata, r2_rdata;
  logic [DW-1:0] rf_din, rf_dout1, rf_dout2;
  logic [AW-1:0] rf_wad1, rf_rad1, rf_rad2;
  logic          rf_wen1, rf_ren1, rf_ren2, rf_collision, err_collision;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  regfile_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .resetn(resetn),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(r1_ready),
    .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_rready(r1_rready),
    .r2_valid(r2_valid), .r2_addr(r2_addr), .r2_ready(r2_ready),
    .r2_rvalid(r2_rvalid), .r2_rdata(r2_rdata), .r2_rready(r2_rready),
    .rf_din(rf_din), .rf_wad1(rf_wad1), .rf_wen1(rf_wen1),
    .rf_rad1(rf_rad1), .rf_rad2(rf_rad2), .rf_ren1(rf_ren1), .rf_ren2(rf_ren2),
    .rf_dout1(rf_dout1), .rf_dout2(rf_dout2), .rf_collision(rf_collision),
    .err_collision(err_collision)
  );

  // Register file model: entry i holds 0x1000_0000 + i out of reset,
  // registered read data, collision flagged on any shared address.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h1000_0000 + i;
      rf_dout1 <= '0;
      rf_dout2 <= '0;
    end else begin
      if (rf_ren1) rf_dout1 <= rf_mem[rf_rad1];
      if (rf_ren2) rf_dout2 <= rf_mem[rf_rad2];
      if (rf_wen1) rf_mem[rf_wad1] <= rf_din;
    end
  end
  assign rf_collision = (rf_wen1 & rf_ren1 & (rf_wad1 == rf_rad1)) |
                        (rf_wen1 & rf_ren2 & (rf_wad1 == rf_rad2)) |
                        (rf_ren1 & rf_ren2 & (rf_rad1 == rf_rad2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: accepted reads push the expected word; responses pop it.
  logic [DW-1:0] exp_mem [32];
  logic [DW-1:0] q1 [$];
  logic [DW-1:0] q2 [$];
  logic [DW-1:0] e;

  always @(negedge clk) begin
    if (!resetn) begin
      q1.delete();
      q2.delete();
      for (int i = 0; i < 32; i++) exp_mem[i] = 32'h1000_0000 + i;
    end else begin
      check("rf_collision", 32'(rf_collision), 32'd0);
      if (r1_rvalid && r1_rready) begin
        if (q1.size() == 0) check("r1 unexpected response", 32'd1, 32'd0);
        else begin e = q1.pop_front(); check("r1 rdata", r1_rdata, e); end
      end
      if (r2_rvalid && r2_rready) begin
        if (q2.size() == 0) check("r2 unexpected response", 32'd1, 32'd0);
        else begin e = q2.pop_front(); check("r2 rdata", r2_rdata, e); end
      end
      if (r1_valid && r1_ready) q1.push_back(exp_mem[r1_addr]);
      if (r2_valid && r2_ready) q2.push_back(exp_mem[r2_addr]);
      if (w_valid && w_ready) exp_mem[w_addr] = w_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    w_valid = 0; r1_valid = 0; r2_valid = 0;
    repeat (n) tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0;
    w_valid = 1; w_addr = 5'd1; w_data = 32'h1;
    r1_valid = 1; r1_addr = 5'd2; r2_valid = 1; r2_addr = 5'd3;
    r1_rready = 1; r2_rready = 1;
    // Reset cycle: every grant forced low even with all valids up.
    @(negedge clk);
    check("reset w_ready", 32'(w_ready), 32'd0);
    check("reset r1_ready", 32'(r1_ready), 32'd0);
    check("reset r2_ready", 32'(r2_ready), 32'd0);
    check("reset rf_wen1", 32'(rf_wen1), 32'd0);
    check("reset rf_ren1", 32'(rf_ren1), 32'd0);
    check("reset rf_ren2", 32'(rf_ren2), 32'd0);
    tick();
    resetn = 1;
    idle(1);
    @(negedge clk);
    check("post-reset r1_rvalid", 32'(r1_rvalid), 32'd0);
    check("post-reset r1_rdata", r1_rdata, 32'd0);
    check("post-reset r2_rvalid", 32'(r2_rvalid), 32'd0);
    check("post-reset err", 32'(err_collision), 32'd0);

    // Write then read back with two-cycle latency.
    tick(); w_valid = 1; w_addr = 5'd3; w_data = 32'hDEADBEEF;
    @(negedge clk); check("t1 w_ready", 32'(w_ready), 32'd1);
    tick(); w_valid = 0; r1_valid = 1; r1_addr = 5'd3;
    @(negedge clk); check("t1 r1_ready", 32'(r1_ready), 32'd1);
    tick(); r1_valid = 0;
    @(negedge clk); check("t1 rvalid at t+1", 32'(r1_rvalid), 32'd0);
    tick();
    @(negedge clk);
    check("t1 rvalid at t+2", 32'(r1_rvalid), 32'd1);
    check("t1 rdata", r1_rdata, 32'hDEADBEEF);
    check("t1 err", 32'(err_collision), 32'd0);
    idle(3);

    // Three-way address conflict resolves R1, then R2, then W.
    w_valid = 1; w_addr = 5'd5; w_data = 32'h5555_5555;
    r1_valid = 1; r1_addr = 5'd5; r2_valid = 1; r2_addr = 5'd5;
    @(negedge clk);
    check("t2c1 r1_ready", 32'(r1_ready), 32'd1);
    check("t2c1 r2_ready", 32'(r2_ready), 32'd0);
    check("t2c1 w_ready", 32'(w_ready), 32'd0);
    tick(); r1_valid = 0;
    @(negedge clk);
    check("t2c2 r2_ready", 32'(r2_ready), 32'd1);
    check("t2c2 w_ready", 32'(w_ready), 32'd0);
    tick(); r2_valid = 0;
    @(negedge clk);
    check("t2c3 w_ready", 32'(w_ready), 32'd1);
    check("t2c3 r1_rdata", r1_rdata, 32'h1000_0005);
    tick(); w_valid = 0;
    @(negedge clk);
    check("t2c4 r2_rvalid", 32'(r2_rvalid), 32'd1);
    check("t2c4 r2_rdata", r2_rdata, 32'h1000_0005);
    idle(3);

    // R1 beats R2 on a shared address; an unrelated write rides along.
    for (int i = 0; i < 4; i++) begin
      r1_valid = 1; r1_addr = 5'd7; r2_valid = 1; r2_addr = 5'd7;
      w_valid = 1; w_addr = 5'd9; w_data = 32'h900 + i;
      @(negedge clk);
      check("t3 r1_ready", 32'(r1_ready), 32'd1);
      check("t3 r2_ready", 32'(r2_ready), 32'd0);
      check("t3 w_ready", 32'(w_ready), 32'd1);
      tick();
    end
    idle(4);

    // Write starved by a conflicting read stream.
    for (int i = 0; i < 6; i++) begin
      r1_valid = 1; r1_addr = 5'd2;
      w_valid = !(GUARD && i == 5); w_addr = 5'd2; w_data = 32'h2222_2222;
      @(negedge clk);
      check("t4 w_ready", 32'(w_ready), 32'(GUARD && i == 4));
      check("t4 r1_ready", 32'(r1_ready), 32'(!(GUARD && i == 4)));
      tick();
    end
    idle(4);

    // Backpressure: two accepts, then stall until a pop frees space.
    r1_rready = 0;
    for (int i = 0; i < 5; i++) begin
      r1_valid = 1; r1_addr = (i == 0) ? 5'd4 : (i == 1) ? 5'd6 : 5'd8;
      @(negedge clk);
      check("t5 r1_ready", 32'(r1_ready), 32'(i < 2));
      tick();
    end
    @(negedge clk);
    check("t5 rvalid held", 32'(r1_rvalid), 32'd1);
    check("t5 head", r1_rdata, 32'h1000_0004);
    tick(); r1_rready = 1;
    @(negedge clk);
    check("t5 resume r1_ready", 32'(r1_ready), 32'd1);
    tick(); r1_valid = 0;
    @(negedge clk);
    check("t5 second entry", r1_rdata, 32'h1000_0006);
    idle(4);

    // Reset right after an accept drops the in-flight read.
    r1_valid = 1; r1_addr = 5'd10;
    @(negedge clk); check("t6 r1_ready", 32'(r1_ready), 32'd1);
    tick();
    resetn = 0; r1_valid = 0;
    w_valid = 1; w_addr = 5'd1; r2_valid = 1; r2_addr = 5'd11;
    @(negedge clk);
    check("t6 reset w_ready", 32'(w_ready), 32'd0);
    check("t6 reset r2_ready", 32'(r2_ready), 32'd0);
    check("t6 reset rf_wen1", 32'(rf_wen1), 32'd0);
    tick(); resetn = 1; w_valid = 0; r2_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6 r1_rvalid", 32'(r1_rvalid), 32'd0);
      check("t6 r1_rdata", r1_rdata, 32'd0);
      check("t6 err", 32'(err_collision), 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
`default_nettype wire
